// File: rtl/tx_frame_serializer_if.sv
// tx_frame_serializer_if: baud tick, send request, frame and serial-line bundle
interface tx_frame_serializer_if #(parameter int FRAME_W = 11);
  logic BaudTick;
  logic Send;
  logic [FRAME_W-1:0] FrameIn;
  logic [1:0] ParityType;
  logic TxOut;
  logic Busy;
  logic Done;
  modport master(output BaudTick, Send, FrameIn, ParityType, input TxOut, Busy, Done);
  modport slave(input BaudTick, Send, FrameIn, ParityType, output TxOut, Busy, Done);
endinterface

// File: rtl/tx_frame_serializer.sv
// tx_frame_serializer: shifts an LSB-first UART frame onto TxOut, one bit per baud tick
module tx_frame_serializer #(
  parameter int FRAME_W = 11
) (
  input logic CLK,
  input logic ResetN,
  tx_frame_serializer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, STOP} state_t;
  state_t state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d, n_q, n_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    n_d = n_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.Send) begin
        shift_d = bus.FrameIn;
        n_d = ^bus.ParityType ? 4'd11 : 4'd10;
        cnt_d = 4'd0;
        busy_d = 1'b1;
        tx_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (bus.BaudTick) begin
        tx_d = shift_q[0];
        cnt_d = 4'd1;
        state_d = SHIFT;
      end
      SHIFT: if (bus.BaudTick) begin
        if (cnt_q < n_q) begin
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          tx_d = shift_q[1];
          cnt_d = cnt_q + 4'd1;
        end else begin
          // last bit has now been held a full period
          tx_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          state_d = STOP;
        end
      end
      default: begin
        tx_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      shift_q <= '1;
      cnt_q <= 4'd0;
      n_q <= 4'd10;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.TxOut = tx_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_tx_frame_serializer.sv
// tb_tx_frame_serializer: table, hand-written and random frames checked against a bit-list model
module tb_tx_frame_serializer;
  logic CLK = 1'b0;
  logic ResetN = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int tcnt = 0;
  tx_frame_serializer_if bus();
  tx_frame_serializer dut (.CLK(CLK), .ResetN(ResetN), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    logic [10:0] frame;
    logic [1:0] par;
    bit inject;
    int n;
    logic [10:0] bits;
  } vec_t;
  vec_t tbl[6];
  initial begin
    bus.BaudTick = 1'b0;
    forever begin
      @(negedge CLK);
      tcnt = (tcnt + 1) % 16;
      bus.BaudTick = (tcnt == 0);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic accept(input logic [10:0] f, input logic [1:0] p);
    bus.FrameIn = f;
    bus.ParityType = p;
    bus.Send = 1'b1;
    @(negedge CLK);
    bus.Send = 1'b0;
    chk("accept_busy", 32'(bus.Busy), 32'd1);
    chk("accept_line_idle", 32'(bus.TxOut), 32'd1);
    bus.FrameIn = 11'($urandom);
    bus.ParityType = 2'($urandom);
  endtask
  task automatic expect_frame(input logic [10:0] bits, input int n, input bit inject);
    int b = 0;
    int dones = 0;
    int busy_lo = 0;
    while (bus.TxOut !== 1'b0 && b < 64) begin
      @(negedge CLK);
      b++;
    end
    chk("start_bit_seen", 32'(b < 64), 32'd1);
    if (b >= 64) return;
    for (int c = 0; c < 16 * n; c++) begin
      if (c % 16 == 8) chk($sformatf("bit%0d", c / 16), 32'(bus.TxOut), 32'(bits[c / 16]));
      if (inject && c == 52) begin
        bus.FrameIn = ~bits;
        bus.ParityType = 2'b01;
        bus.Send = 1'b1;
      end
      if (inject && c == 53) bus.Send = 1'b0;
      dones += int'(bus.Done);
      busy_lo += int'(!bus.Busy);
      @(negedge CLK);
    end
    chk("done_at_end", 32'(bus.Done), 32'd1);
    chk("busy_low_in_stop", 32'(bus.Busy), 32'd0);
    chk("no_early_done", 32'(dones), 32'd0);
    chk("busy_through_frame", 32'(busy_lo), 32'd0);
  endtask
  task automatic after_frame();
    int bad = 0;
    @(negedge CLK);
    chk("done_single_cycle", 32'(bus.Done), 32'd0);
    for (int i = 0; i < 40; i++) begin
      bad += int'(bus.TxOut !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0);
      @(negedge CLK);
    end
    chk("idle_quiet", 32'(bad), 32'd0);
  endtask
  initial begin
    int bad;
    logic [10:0] f;
    logic [1:0] p;
    logic [10:0] held[3];
    bus.Send = 1'b0;
    bus.FrameIn = '1;
    bus.ParityType = 2'b00;
    tbl[0] = '{11'h74A, 2'b00, 1'b0, 10, 11'h34A};
    tbl[1] = '{11'h54A, 2'b01, 1'b0, 11, 11'h54A};
    tbl[2] = '{11'h54A, 2'b11, 1'b0, 10, 11'h14A};
    tbl[3] = '{11'h7FE, 2'b10, 1'b0, 11, 11'h7FE};
    tbl[4] = '{11'h000, 2'b00, 1'b0, 10, 11'h000};
    tbl[5] = '{11'h74A, 2'b00, 1'b1, 10, 11'h34A};
    repeat (3) @(negedge CLK);
    chk("reset_tx", 32'(bus.TxOut), 32'd1);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_done", 32'(bus.Done), 32'd0);
    ResetN = 1'b1;
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].frame, tbl[i].par);
      expect_frame(tbl[i].bits, tbl[i].n, tbl[i].inject);
      after_frame();
    end
    // Send coinciding with a tick: that tick must not launch the start bit
    @(posedge CLK iff bus.BaudTick);
    repeat (16) @(negedge CLK);
    bus.FrameIn = 11'h74A;
    bus.ParityType = 2'b00;
    bus.Send = 1'b1;
    @(negedge CLK);
    bus.Send = 1'b0;
    chk("tick_accept_busy", 32'(bus.Busy), 32'd1);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      bad += int'(bus.TxOut !== 1'b1);
    end
    chk("tick_line_held", 32'(bad), 32'd0);
    @(negedge CLK);
    chk("tick_start_next", 32'(bus.TxOut), 32'd0);
    expect_frame(11'h34A, 10, 1'b0);
    after_frame();
    for (int i = 0; i < 3; i++) held[i] = (11'($urandom) & 11'h7FE);
    bus.FrameIn = held[0];
    bus.ParityType = 2'b00;
    bus.Send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_frame(held[i], 10, 1'b0);
      if (i < 2) bus.FrameIn = held[i + 1];
      else bus.Send = 1'b0;
    end
    after_frame();
    accept(11'h74A, 2'b00);
    bad = 0;
    while (bus.TxOut !== 1'b0 && bad < 64) begin
      @(negedge CLK);
      bad++;
    end
    repeat (16 * 4 + 4) @(negedge CLK);
    chk("pre_reset_bit4", 32'(bus.TxOut), 32'd0);
    #2 ResetN = 1'b0;
    #1;
    chk("async_reset_tx", 32'(bus.TxOut), 32'd1);
    chk("async_reset_busy", 32'(bus.Busy), 32'd0);
    chk("async_reset_done", 32'(bus.Done), 32'd0);
    @(negedge CLK);
    ResetN = 1'b1;
    after_frame();
    for (int i = 0; i < 10; i++) begin
      f = 11'($urandom) & 11'h7FE;
      p = 2'($urandom);
      accept(f, p);
      expect_frame(f, (p == 2'b01 || p == 2'b10) ? 11 : 10, 1'b0);
      after_frame();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
